// File: rtl/bsg_tag_serializer.sv
// Transmit end of the bsg_tag serial protocol: a master-reset preamble after
// reset, then one bit-serial frame per accepted packet, separated by idle gaps.
module bsg_tag_serializer #(
   parameter int els_p        = 32,
   parameter int lg_width_p   = 4,
   parameter int reset_ones_p = 64,
   parameter int gap_bits_p   = 1,
   localparam int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int pay_w_lp    = (1 << lg_width_p) - 1
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  v_i,
   output logic                  ready_o,
   input  logic [lg_els_lp-1:0]  client_id_i,
   input  logic                  data_not_reset_i,
   input  logic [lg_width_p-1:0] len_i,
   input  logic [pay_w_lp-1:0]   payload_i,
   output logic                  tag_data_o,
   output logic                  init_done_o,
   output logic                  busy_o
);

   localparam int hdr_lp   = lg_els_lp + 1 + lg_width_p;
   localparam int sh_w_lp  = hdr_lp + pay_w_lp;
   localparam int frm_lp   = 1 + sh_w_lp;
   localparam int mx_a_lp  = (reset_ones_p > frm_lp) ? reset_ones_p : frm_lp;
   localparam int mx_lp    = (mx_a_lp > gap_bits_p) ? mx_a_lp : gap_bits_p;
   localparam int cw_lp    = $clog2(mx_lp + 1);

   typedef enum logic [1:0] {
      S_PRE,
      S_GAP,
      S_IDLE,
      S_SHIFT
   } state_e;

   state_e              r_state;
   state_e              w_state_n;
   logic [cw_lp-1:0]    r_cnt;
   logic [cw_lp-1:0]    w_cnt_n;
   logic [sh_w_lp-1:0]  r_shift;
   logic [sh_w_lp-1:0]  w_shift_n;
   logic                r_tag;
   logic                w_tag_n;
   logic                r_init;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= S_PRE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_tag   <= 1'b0;
         r_init  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_shift <= w_shift_n;
         r_tag   <= w_tag_n;
         r_init  <= r_init | (w_state_n == S_IDLE);
      end
   end

   // r_tag holds the bit for the current cycle; w_tag_n is the next one,
   // so the start bit goes out the cycle right after the handshake.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_shift_n = r_shift;
      w_tag_n   = 1'b0;
      case (r_state)
         S_PRE: begin
            w_tag_n = 1'b1;
            if (r_cnt == cw_lp'(reset_ones_p - 1)) begin
               w_state_n = S_GAP;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = r_cnt + cw_lp'(1);
            end
         end
         S_GAP: begin
            if (r_cnt == cw_lp'(gap_bits_p - 1)) begin
               w_state_n = S_IDLE;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = r_cnt + cw_lp'(1);
            end
         end
         S_IDLE: begin
            if (v_i) begin
               w_tag_n   = 1'b1;
               w_shift_n = {payload_i, len_i, data_not_reset_i, client_id_i};
               w_cnt_n   = cw_lp'(hdr_lp) + cw_lp'(len_i);
               w_state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // r_cnt counts frame bits still to send after the start bit
            w_tag_n   = r_shift[0];
            w_shift_n = r_shift >> 1;
            if (r_cnt == cw_lp'(1)) begin
               w_state_n = S_GAP;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = r_cnt - cw_lp'(1);
            end
         end
         default: begin
            w_state_n = S_PRE;
            w_cnt_n   = '0;
         end
      endcase
   end

   assign ready_o     = (r_state == S_IDLE);
   assign busy_o      = (r_state != S_IDLE);
   assign tag_data_o  = r_tag;
   assign init_done_o = r_init;

endmodule
